// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
package imem_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IMEM_OK       = 2'b00,
        IMEM_MISALIGN = 2'b01,
        IMEM_OOR      = 2'b10
    } imem_err_e;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        CAPTURE,
        RESP
    } imem_state_e;

    // Misalignment wins over range; the range test uses the full 62-bit word index.
    function automatic imem_err_e check_addr(input logic [63:0] addr, input int unsigned depth);
        if (addr[1:0] != 2'b00) begin
            return IMEM_MISALIGN;
        end
        if (addr[63:2] >= 62'(depth)) begin
            return IMEM_OOR;
        end
        return IMEM_OK;
    endfunction

endpackage

// File: rtl/imem_array.sv
// DEPTH x 32 instruction storage: one sync write port, one sync read port,
// read-before-write on a same-address collision. Contents are never reset.
module imem_array
    import imem_pkg::*;
#(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [31:0]   wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [31:0]   rd_data
);

    logic [31:0] mem [DEPTH];

    // Read and write share an edge; non-blocking update yields the old word on a collision.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

endmodule

// File: rtl/imem_responder.sv
// Instruction-fetch responder: one outstanding request, fixed LATENCY to
// resp_valid, misaligned/out-of-range flagging, side-band preload port.
module imem_responder
    import imem_pkg::*;
#(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [63:0]              req_addr,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [31:0]              resp_instr,
    output logic [1:0]               resp_err,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [31:0]              wr_data
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam int unsigned CW       = (LATENCY > 2) ? $clog2(LATENCY) : 1;
    localparam int unsigned CNT_INIT = (LATENCY >= 2) ? LATENCY - 2 : 0;

    imem_state_e state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [63:0]   addr_q;
    logic          accept;
    imem_err_e     cap_err;
    imem_err_e     resp_err_q;
    logic          data_ok_q;
    logic          rd_en;
    logic [31:0]   rd_data;

    assign cap_err = check_addr(addr_q, DEPTH);
    assign rd_en   = (state == CAPTURE) && (cap_err == IMEM_OK);

    imem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (addr_q[2 +: AW]),
        .rd_data (rd_data)
    );

    // Next-state, handshake outputs and latency counter; acceptance in RESP reuses the IDLE path.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                accept    = req_valid;
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_nxt = CAPTURE;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            CAPTURE: begin
                state_nxt = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                req_ready  = resp_ready;
                if (resp_ready) begin
                    if (req_valid) begin
                        accept = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (accept) begin
            if (LATENCY == 1) begin
                state_nxt = CAPTURE;
            end else begin
                state_nxt = WAIT;
                cnt_nxt   = CW'(CNT_INIT);
            end
        end
    end

    // State, counter, latched address and response status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            addr_q     <= '0;
            resp_err_q <= IMEM_OK;
            data_ok_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                addr_q <= req_addr;
            end
            if (state == CAPTURE) begin
                resp_err_q <= cap_err;
                data_ok_q  <= (cap_err == IMEM_OK);
            end
        end
    end

    // The storage read register already holds the word, so only the error/NOP/reset selection is added here.
    always_comb begin
        if (data_ok_q) begin
            resp_instr = rd_data;
        end else if (resp_err_q != IMEM_OK) begin
            resp_instr = NOP_INSTR;
        end else begin
            resp_instr = '0;
        end
    end

    assign resp_err = resp_err_q;

endmodule
